// File: rtl/reg_file_arbiter_if.sv
// Requester-side and register-file-side signals of the two-port register file arbiter.
// The arbiter uses the slave view; the environment (requesters plus file) uses the master view.
interface reg_file_arbiter_if #(
    parameter int reg_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  Req0;
    logic                  Req1;
    logic                  Wr0;
    logic                  Wr1;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [reg_WIDTH-1:0]  WrData0;
    logic [reg_WIDTH-1:0]  WrData1;
    logic                  Gnt0;
    logic                  Gnt1;
    logic [reg_WIDTH-1:0]  RdData0;
    logic [reg_WIDTH-1:0]  RdData1;
    logic                  RdValid0;
    logic                  RdValid1;
    logic                  Busy;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [reg_WIDTH-1:0]  WrData;
    logic [reg_WIDTH-1:0]  RfRdData;

    modport slave (
        input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, WrData0, WrData1, RfRdData,
        output Gnt0, Gnt1, RdData0, RdData1, RdValid0, RdValid1, Busy,
               WrEn, RdEn, Address, WrData
    );

    modport master (
        output Req0, Req1, Wr0, Wr1, Addr0, Addr1, WrData0, WrData1, RfRdData,
        input  Gnt0, Gnt1, RdData0, RdData1, RdValid0, RdValid1, Busy,
               WrEn, RdEn, Address, WrData
    );
endinterface

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter/sequencer sharing one register file port between two requesters.
// IDLE samples requests, ACCESS drives one command cycle, RESP returns registered read data.
module reg_file_arbiter #(
    parameter int reg_WIDTH  = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                CLK,
    input  logic                RST,
    reg_file_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q;
    logic                  last_q;
    logic                  who_q;
    logic                  rd_op_q;
    logic                  gnt0_q;
    logic                  gnt1_q;
    logic [reg_WIDTH-1:0]  rd_data0_q;
    logic [reg_WIDTH-1:0]  rd_data1_q;
    logic                  rd_valid0_q;
    logic                  rd_valid1_q;
    logic                  busy_q;
    logic                  wr_en_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] address_q;
    logic [reg_WIDTH-1:0]  wr_data_q;

    logic                  any_req_d;
    logic                  winner_d;
    logic                  win_wr_d;
    logic [ADDR_WIDTH-1:0] win_addr_d;
    logic [reg_WIDTH-1:0]  win_data_d;

    // Winner selection: on contention the requester not granted last goes first.
    always_comb begin
        any_req_d = bus.Req0 | bus.Req1;
        if (bus.Req0 && bus.Req1) begin
            winner_d = ~last_q;
        end else if (bus.Req0) begin
            winner_d = 1'b0;
        end else begin
            winner_d = 1'b1;
        end
        if (winner_d) begin
            win_wr_d   = bus.Wr1;
            win_addr_d = bus.Addr1;
            win_data_d = bus.WrData1;
        end else begin
            win_wr_d   = bus.Wr0;
            win_addr_d = bus.Addr0;
            win_data_d = bus.WrData0;
        end
    end

    // Access sequencer with all outputs registered; pulses default low every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            who_q       <= 1'b0;
            rd_op_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rd_data0_q  <= '0;
            rd_data1_q  <= '0;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            address_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        state_q   <= ACCESS;
                        busy_q    <= 1'b1;
                        gnt0_q    <= ~winner_d;
                        gnt1_q    <= winner_d;
                        address_q <= win_addr_d;
                        wr_data_q <= win_data_d;
                        wr_en_q   <= win_wr_d;
                        rd_en_q   <= ~win_wr_d;
                        who_q     <= winner_d;
                        rd_op_q   <= ~win_wr_d;
                        last_q    <= winner_d;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                    if (rd_op_q) begin
                        state_q <= RESP;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // The file registered its read at the end of ACCESS, so RfRdData is valid now.
                    if (who_q) begin
                        rd_data1_q  <= bus.RfRdData;
                        rd_valid1_q <= 1'b1;
                    end else begin
                        rd_data0_q  <= bus.RfRdData;
                        rd_valid0_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Gnt0     = gnt0_q;
    assign bus.Gnt1     = gnt1_q;
    assign bus.RdData0  = rd_data0_q;
    assign bus.RdData1  = rd_data1_q;
    assign bus.RdValid0 = rd_valid0_q;
    assign bus.RdValid1 = rd_valid1_q;
    assign bus.Busy     = busy_q;
    assign bus.WrEn     = wr_en_q;
    assign bus.RdEn     = rd_en_q;
    assign bus.Address  = address_q;
    assign bus.WrData   = wr_data_q;
endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: transaction-level occupancy model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reg_file_arbiter;
    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    reg_file_arbiter_if #(.reg_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    reg_file_arbiter #(.reg_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file stand-in: synchronous write, registered read.
    logic [15:0] rf [8];
    always @(posedge CLK) begin
        if (bus.WrEn) rf[bus.Address] <= bus.WrData;
        if (bus.RdEn) bus.RfRdData <= rf[bus.Address];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: a grant occupies the port for 1 (write) or 2 (read) further edges;
    // a read returns the file contents as they were at grant time.
    logic [15:0] m_mem [8];
    int          m_occ;
    int          m_last;
    bit          m_ok = 1'b0;
    bit          m_pend;
    int          m_who;
    logic [15:0] m_val;
    logic        e_gnt0, e_gnt1, e_rv0, e_rv1, e_busy, e_wren, e_rden;
    logic [15:0] e_rd0, e_rd1, e_wdata;
    logic [2:0]  e_addr;

    always @(posedge CLK) begin
        if (RST) begin
            m_occ = 0; m_last = 1; m_pend = 1'b0; m_ok = 1'b1;
            e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_busy = 1'b0;
            e_wren = 1'b0; e_rden = 1'b0; e_rd0 = 16'd0; e_rd1 = 16'd0;
            e_wdata = 16'd0; e_addr = 3'd0;
        end else begin
            e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
            e_wren = 1'b0; e_rden = 1'b0;
            if (m_occ > 0) begin
                m_occ = m_occ - 1;
                if (m_occ == 0 && m_pend) begin
                    m_pend = 1'b0;
                    if (m_who == 0) begin e_rv0 = 1'b1; e_rd0 = m_val; end
                    else begin e_rv1 = 1'b1; e_rd1 = m_val; end
                end
            end else if (bus.Req0 || bus.Req1) begin
                if (bus.Req0 && bus.Req1) m_who = 1 - m_last;
                else m_who = bus.Req0 ? 0 : 1;
                m_last = m_who;
                e_addr  = (m_who == 0) ? bus.Addr0 : bus.Addr1;
                e_wdata = (m_who == 0) ? bus.WrData0 : bus.WrData1;
                e_wren  = (m_who == 0) ? bus.Wr0 : bus.Wr1;
                e_rden  = ~e_wren;
                e_gnt0  = (m_who == 0);
                e_gnt1  = (m_who == 1);
                if (e_wren) begin
                    m_mem[e_addr] = e_wdata;
                    m_occ = 1;
                end else begin
                    m_val = m_mem[e_addr];
                    m_pend = 1'b1;
                    m_occ = 2;
                end
            end
            e_busy = (m_occ != 0);
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge CLK) begin
        if (m_ok) begin
            chk("gnt0",     32'(bus.Gnt0),     32'(e_gnt0));
            chk("gnt1",     32'(bus.Gnt1),     32'(e_gnt1));
            chk("rdvalid0", 32'(bus.RdValid0), 32'(e_rv0));
            chk("rdvalid1", 32'(bus.RdValid1), 32'(e_rv1));
            chk("rddata0",  32'(bus.RdData0),  32'(e_rd0));
            chk("rddata1",  32'(bus.RdData1),  32'(e_rd1));
            chk("busy",     32'(bus.Busy),     32'(e_busy));
            chk("wren",     32'(bus.WrEn),     32'(e_wren));
            chk("rden",     32'(bus.RdEn),     32'(e_rden));
            chk("address",  32'(bus.Address),  32'(e_addr));
            chk("wrdata",   32'(bus.WrData),   32'(e_wdata));
            chk("wr_rd_excl", 32'(bus.WrEn & bus.RdEn), 32'd0);
        end
    end

    task automatic wait_gnt(input int who, input string nm);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (((who == 0) ? bus.Gnt0 : bus.Gnt1) !== 1'b1 && n < 20);
        chk(nm, 32'((who == 0) ? bus.Gnt0 : bus.Gnt1), 32'd1);
    endtask

    initial begin
        int bcnt, g1cnt, wecnt, rv0cnt, rv1cnt;
        for (int i = 0; i < 8; i++) begin rf[i] = 16'd0; m_mem[i] = 16'd0; end
        bus.RfRdData = 16'd0;
        RST = 1'b1;
        bus.Req0 = 1'b1; bus.Wr0 = 1'b1; bus.Addr0 = 3'd0; bus.WrData0 = 16'd11;
        bus.Req1 = 1'b1; bus.Wr1 = 1'b1; bus.Addr1 = 3'd7; bus.WrData1 = 16'd22;

        // Reset held with both requesting
        repeat (2) @(negedge CLK);
        chk("rst_gnt0", 32'(bus.Gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.Gnt1), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_wren", 32'(bus.WrEn), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("first_gnt0", 32'(bus.Gnt0), 32'd1);
        chk("first_gnt1", 32'(bus.Gnt1), 32'd0);
        bus.Req0 = 1'b0;
        wait_gnt(1, "first_gnt1_later");
        bus.Req1 = 1'b0;
        repeat (3) @(negedge CLK);

        // Single write then read, requester 0
        bus.Req0 = 1'b1; bus.Wr0 = 1'b1; bus.Addr0 = 3'd6; bus.WrData0 = 16'd840;
        wait_gnt(0, "wr_gnt0");
        chk("wr_wren", 32'(bus.WrEn), 32'd1);
        chk("wr_addr", 32'(bus.Address), 32'd6);
        chk("wr_data", 32'(bus.WrData), 32'd840);
        bus.Req0 = 1'b0;
        @(negedge CLK);
        chk("wr_wren_drop", 32'(bus.WrEn), 32'd0);
        chk("wr_gnt0_drop", 32'(bus.Gnt0), 32'd0);
        @(negedge CLK);
        bus.Req0 = 1'b1; bus.Wr0 = 1'b0;
        wait_gnt(0, "rd_gnt0");
        bus.Req0 = 1'b0;
        @(negedge CLK);
        chk("rd_rv0_early", 32'(bus.RdValid0), 32'd0);
        @(negedge CLK);
        chk("rd_rv0", 32'(bus.RdValid0), 32'd1);
        chk("rd_data0", 32'(bus.RdData0), 32'd840);
        chk("rd_rv1", 32'(bus.RdValid1), 32'd0);
        repeat (2) @(negedge CLK);

        // Contention, both writing; requester 0 was granted last so requester 1 leads
        bus.Req0 = 1'b1; bus.Wr0 = 1'b1; bus.Addr0 = 3'd5; bus.WrData0 = 16'd900;
        bus.Req1 = 1'b1; bus.Wr1 = 1'b1; bus.Addr1 = 3'd1; bus.WrData1 = 16'd620;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("cont_gnt0", 32'(bus.Gnt0), (i == 2 || i == 6) ? 32'd1 : 32'd0);
            chk("cont_gnt1", 32'(bus.Gnt1), (i == 0 || i == 4) ? 32'd1 : 32'd0);
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        repeat (2) @(negedge CLK);

        // Mixed contention, both reading preloaded addresses
        bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 3'd5;
        bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 3'd1;
        rv0cnt = 0; rv1cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.Gnt0 === 1'b1) bus.Req0 = 1'b0;
            if (bus.Gnt1 === 1'b1) bus.Req1 = 1'b0;
            if (bus.RdValid0 === 1'b1) rv0cnt++;
            if (bus.RdValid1 === 1'b1) rv1cnt++;
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        chk("mix_rv0_count", 32'(rv0cnt), 32'd1);
        chk("mix_rv1_count", 32'(rv1cnt), 32'd1);
        chk("mix_rd0", 32'(bus.RdData0), 32'd900);
        chk("mix_rd1", 32'(bus.RdData1), 32'd620);

        // Withdrawal: Req1 raised during a requester-0 read and dropped before Busy falls
        bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 3'd6;
        wait_gnt(0, "wd_gnt0");
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b1; bus.Wr1 = 1'b1; bus.Addr1 = 3'd3; bus.WrData1 = 16'd77;
        bcnt = int'(bus.Busy); g1cnt = 0; wecnt = 0;
        @(negedge CLK);
        bcnt += int'(bus.Busy);
        bus.Req1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            bcnt  += int'(bus.Busy);
            g1cnt += int'(bus.Gnt1);
            wecnt += int'(bus.WrEn);
        end
        chk("wd_busy_cycles", 32'(bcnt), 32'd2);
        chk("wd_no_gnt1", 32'(g1cnt), 32'd0);
        chk("wd_no_write", 32'(wecnt), 32'd0);
        chk("wd_rd0", 32'(bus.RdData0), 32'd840);

        // Reset during RESP abandons the read
        bus.Req0 = 1'b1; bus.Wr0 = 1'b0; bus.Addr0 = 3'd5;
        wait_gnt(0, "rr_gnt0");
        bus.Req0 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rr_rv0", 32'(bus.RdValid0), 32'd0);
        chk("rr_rd0", 32'(bus.RdData0), 32'd0);
        chk("rr_busy", 32'(bus.Busy), 32'd0);
        RST = 1'b0;
        bus.Req1 = 1'b1; bus.Wr1 = 1'b0; bus.Addr1 = 3'd1;
        wait_gnt(1, "rr_gnt1");
        bus.Req1 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rr_rv1", 32'(bus.RdValid1), 32'd1);
        chk("rr_rd1", 32'(bus.RdData1), 32'd620);
        repeat (2) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
